// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY transmit-path definitions: K28.5 comma symbol,
// serializer state encoding and FIFO level sizing helper.
package pcie_phy_pkg;

  localparam logic [7:0] K28_5_COM = 8'hBC;

  typedef enum logic {
    PS_LOAD  = 1'b0,
    PS_SHIFT = 1'b1
  } ps_state_e;

  // Bits needed to hold a fill level in 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ps_sync_fifo.sv
// Single-clock symbol FIFO with wrapping read/write pointers and an explicit
// level counter. A push when full or a pop when empty is ignored.
module ps_sync_fifo
  import pcie_phy_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            push,
  input  logic [WIDTH-1:0]                wdata,
  input  logic                            pop,
  output logic [WIDTH-1:0]                rdata,
  output logic                            full,
  output logic                            empty,
  output logic [level_width(DEPTH)-1:0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = level_width(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state flops use non-blocking assignment so all update together at the edge.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is not reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/paralelo_serial_cfg.sv
// Parallel-to-serial converter for the PCIe PHY transmit path with idle-symbol
// fill. Define PS_LSB_FIRST_EN to shift each symbol LSB first (default MSB first).
module paralelo_serial_cfg
  import pcie_phy_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] IDLE_SYM = WIDTH'(K28_5_COM)
) (
  input  logic                           clk_32f,
  input  logic                           reset_L,
  input  logic [WIDTH-1:0]               data_in,
  input  logic                           valid_in,
  output logic                           ready_out,
  output logic                           data_out,
  output logic                           sym_start,
  output logic                           idle_out,
  output logic [level_width(DEPTH)-1:0]  fifo_level
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             data_out_q, data_out_d;
  logic             sym_start_q, sym_start_d;
  logic             idle_out_q, idle_out_d;
  logic [WIDTH-1:0] fifo_rdata, load_sym;
  logic             fifo_pop, fifo_full, fifo_empty;
  ps_state_e        state;

  ps_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_32f),
    .rst_n (reset_L),
    .push  (valid_in && ready_out),
    .wdata (data_in),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign ready_out = !fifo_full;
  assign data_out  = data_out_q;
  assign sym_start = sym_start_q;
  assign idle_out  = idle_out_q;

  // bit_cnt is zero after reset and after the last bit, so both cases load.
  always_comb begin
    state       = (bit_cnt_q == '0) ? PS_LOAD : PS_SHIFT;
    load_sym    = fifo_empty ? IDLE_SYM : fifo_rdata;
    fifo_pop    = 1'b0;
    sh_d        = sh_q;
    bit_cnt_d   = bit_cnt_q;
    data_out_d  = data_out_q;
    sym_start_d = 1'b0;
    idle_out_d  = idle_out_q;
    if (state == PS_LOAD) begin
      fifo_pop    = !fifo_empty;
      idle_out_d  = fifo_empty;
      sh_d        = load_sym;
      bit_cnt_d   = LAST_CNT;
      sym_start_d = 1'b1;
`ifdef PS_LSB_FIRST_EN
      data_out_d  = load_sym[0];
`else
      data_out_d  = load_sym[WIDTH-1];
`endif
    end else begin
      bit_cnt_d   = bit_cnt_q - CW'(1);
`ifdef PS_LSB_FIRST_EN
      data_out_d  = sh_q[1];
      sh_d        = sh_q >> 1;
`else
      data_out_d  = sh_q[WIDTH-2];
      sh_d        = sh_q << 1;
`endif
    end
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      sh_q        <= '0;
      bit_cnt_q   <= '0;
      data_out_q  <= 1'b0;
      sym_start_q <= 1'b0;
      idle_out_q  <= 1'b0;
    end else begin
      sh_q        <= sh_d;
      bit_cnt_q   <= bit_cnt_d;
      data_out_q  <= data_out_d;
      sym_start_q <= sym_start_d;
      idle_out_q  <= idle_out_d;
    end
  end

endmodule

// File: tb/tb_paralelo_serial_cfg.sv
// Self-checking bench: two converter instances (8-bit/depth 4 and 10-bit/depth 8)
// compared every cycle against a queue-based model of the serial stream.
module tb_paralelo_serial_cfg;

  logic       clk;
  logic       reset_L;
  logic       vld  [2];
  logic [9:0] dat  [2];
  logic       rdy  [2];
  logic       dout [2];
  logic       ss   [2];
  logic       idl  [2];
  logic [2:0] lvl0;
  logic [3:0] lvl1;

  int checks = 0;
  int errors = 0;

  // Model: pending symbols, current symbol, its idle flag, edges since reset.
  logic [9:0] mq    [2][$];
  logic [9:0] cur   [2];
  logic       cidle [2];
  int         cyc   [2];
  logic       acc   [2];
  logic       e_bit [2];
  logic       e_ss  [2];

  int         wid [2] = '{8, 10};
  int         dep [2] = '{4, 8};
  logic [9:0] isym[2] = '{10'h0BC, 10'h17C};

  paralelo_serial_cfg #(.WIDTH(8), .DEPTH(4)) dut8 (
    .clk_32f    (clk),
    .reset_L    (reset_L),
    .data_in    (dat[0][7:0]),
    .valid_in   (vld[0]),
    .ready_out  (rdy[0]),
    .data_out   (dout[0]),
    .sym_start  (ss[0]),
    .idle_out   (idl[0]),
    .fifo_level (lvl0)
  );

  paralelo_serial_cfg #(.WIDTH(10), .DEPTH(8), .IDLE_SYM(10'h17C)) dut10 (
    .clk_32f    (clk),
    .reset_L    (reset_L),
    .data_in    (dat[1]),
    .valid_in   (vld[1]),
    .ready_out  (rdy[1]),
    .data_out   (dout[1]),
    .sym_start  (ss[1]),
    .idle_out   (idl[1]),
    .fifo_level (lvl1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] level_of(input int i);
    return (i == 0) ? 32'(lvl0) : 32'(lvl1);
  endfunction

  // One clock: check handshake, advance model at the edge, check outputs #1 later.
  task automatic tick();
    int pos;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("dut%0d ready_out", i), 32'(rdy[i]), 32'(mq[i].size() < dep[i]));
      acc[i] = vld[i] && (mq[i].size() < dep[i]);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      pos = cyc[i] % wid[i];
      if (pos == 0) begin
        if (mq[i].size() > 0) begin
          cur[i]   = mq[i].pop_front();
          cidle[i] = 1'b0;
        end else begin
          cur[i]   = isym[i];
          cidle[i] = 1'b1;
        end
      end
      if (acc[i]) mq[i].push_back((i == 0) ? {2'b00, dat[i][7:0]} : dat[i]);
`ifdef PS_LSB_FIRST_EN
      e_bit[i] = cur[i][pos];
`else
      e_bit[i] = cur[i][wid[i] - 1 - pos];
`endif
      e_ss[i] = (pos == 0);
      cyc[i]++;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("dut%0d data_out cyc%0d", i, cyc[i] - 1), 32'(dout[i]), 32'(e_bit[i]));
      check($sformatf("dut%0d sym_start cyc%0d", i, cyc[i] - 1), 32'(ss[i]), 32'(e_ss[i]));
      check($sformatf("dut%0d idle_out cyc%0d", i, cyc[i] - 1), 32'(idl[i]), 32'(cidle[i]));
      check($sformatf("dut%0d fifo_level cyc%0d", i, cyc[i] - 1), level_of(i), 32'(mq[i].size()));
    end
    @(negedge clk);
  endtask

  // Async reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    #2;
    reset_L = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("dut%0d rst data_out", i), 32'(dout[i]), 32'd0);
      check($sformatf("dut%0d rst sym_start", i), 32'(ss[i]), 32'd0);
      check($sformatf("dut%0d rst idle_out", i), 32'(idl[i]), 32'd0);
      check($sformatf("dut%0d rst fifo_level", i), level_of(i), 32'd0);
      check($sformatf("dut%0d rst ready_out", i), 32'(rdy[i]), 32'd1);
      mq[i].delete();
      cyc[i] = 0;
      vld[i] = 1'b0;
      dat[i] = '0;
    end
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  initial begin
    int nxt;
    reset_L = 1'b1;
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0;
      dat[i] = '0;
    end

    // Idle only: three 8-bit symbols of comma fill.
    do_reset();
    for (int c = 0; c < 30; c++) tick();

    // Single push on the first edge after reset; emitted at the next LOAD.
    do_reset();
    vld[0] = 1'b1;
    dat[0] = 10'h0A5;
    tick();
    vld[0] = 1'b0;
    for (int c = 0; c < 30; c++) tick();

    // Held valid with 0x01..0x06 into depth 4: back-pressure, order, no loss.
    do_reset();
    nxt = 1;
    for (int c = 0; c < 200 && nxt <= 6; c++) begin
      vld[0] = 1'b1;
      dat[0] = 10'(nxt);
      tick();
      if (acc[0]) nxt++;
    end
    check("burst accepted count", 32'(nxt), 32'd7);
    vld[0] = 1'b0;
    for (int c = 0; c < 60; c++) tick();

    // Reset mid-symbol: 0x5A shifting with two words queued.
    do_reset();
    vld[0] = 1'b1;
    dat[0] = 10'h05A;
    tick();
    dat[0] = 10'h011;
    tick();
    dat[0] = 10'h022;
    tick();
    vld[0] = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    do_reset();
    for (int c = 0; c < 30; c++) tick();

    // Random traffic on both instances.
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 2; i++) begin
        vld[i] = 1'($urandom_range(0, 1));
        dat[i] = 10'($urandom);
      end
      tick();
    end
    for (int i = 0; i < 2; i++) vld[i] = 1'b0;
    for (int c = 0; c < 100; c++) tick();
    for (int i = 0; i < 2; i++)
      check($sformatf("dut%0d drained level", i), level_of(i), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
